// File: rtl/ect_uart_pkg.sv
// Shared UART definitions: parity encodings, default bit period, TX shifter states.
package ect_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int CLK_HZ               = 50_000_000;
    localparam int BAUD                 = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Even parity is the plain XOR of the data bits; odd is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte handshake between the upstream sender and the UART transmitter, plus line status.
interface uart_byte_tx_if;

    logic [7:0] UARTSend;
    logic       UARTDatLock;
    logic       UARTAvl;
    logic       TxD;
    logic       TxBusy;
    logic       TxOverrun;

    modport master (
        output UARTSend, UARTDatLock,
        input  UARTAvl, TxD, TxBusy, TxOverrun
    );

    modport slave (
        input  UARTSend, UARTDatLock,
        output UARTAvl, TxD, TxBusy, TxOverrun
    );

endinterface

// File: rtl/ect_baud_cnt.sv
// Bit-period down-counter: load restarts a full period, tick_o marks its last cycle.
module ect_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic tick_o
);

    localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter with a one-byte holding register ahead of the shifter,
// so back-to-back requests produce frames with no idle gap between them.
module uart_byte_tx
    import ect_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic          Clk,
    input  logic          Rst,
    uart_byte_tx_if.slave bus
);

    localparam bit   HAS_PARITY = (PARITY != PAR_NONE);
    localparam logic STOP_LAST  = (STOP_BITS == 2);

    tx_state_e  state_q, state_d;
    logic       dat_lock_q;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;

    logic req, accept, load_frame, cnt_load, bit_tick;

    ect_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (Clk),
        .rst_n (Rst),
        .load_i(cnt_load),
        .tick_o(bit_tick)
    );

    always_comb begin
        req        = bus.UARTDatLock & ~dat_lock_q;
        accept     = req & ~hold_valid_q;
        overrun_d  = req & hold_valid_q;
        load_frame = 1'b0;
        cnt_load   = 1'b0;
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        txd_d      = txd_q;
        hold_d       = accept ? bus.UARTSend : hold_q;
        hold_valid_d = hold_valid_q | accept;

        unique case (state_q)
            ST_IDLE: begin
                load_frame = hold_valid_q;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                    cnt_load  = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    cnt_load = 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        if (HAS_PARITY) begin
                            state_d = ST_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    txd_d      = 1'b1;
                    cnt_load   = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        // A queued byte starts in this same edge: no idle cycles between frames.
                        load_frame = hold_valid_q;
                        state_d    = ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                        cnt_load   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        if (load_frame) begin
            state_d      = ST_START;
            shift_d      = hold_q;
            par_d        = parity_bit(hold_q, PARITY);
            txd_d        = 1'b0;
            cnt_load     = 1'b1;
            hold_valid_d = 1'b0;
        end

        busy_d = hold_valid_d | (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            dat_lock_q   <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dat_lock_q   <= bus.UARTDatLock;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            txd_q        <= txd_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.UARTAvl   = ~hold_valid_q;
    assign bus.TxD       = txd_q;
    assign bus.TxBusy    = busy_q;
    assign bus.TxOverrun = overrun_q;

endmodule
